// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data RAM (and its MMIO digit register) between the
// CPU MEM stage and a DMA/loader engine. Each access is latched on grant and
// then walks IDLE -> ACCESS -> RESP. The owner gets a one-cycle ack together
// with registered read data and an error flag.
// Arbitration rules:
//  - Alternates on contention.
//  - A locked DMA stream may hold the grant for at most MAX_BURST consecutive
//    accesses while the CPU is waiting.
// Every memory-facing output is a flop, so nothing reaches the memory
// combinationally from the request inputs.

module dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0800,
  parameter logic [31:0] MMIO_ADDR  = 32'h4000_0010,
  parameter int          MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy,
  output logic        owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic             last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             we_q;
  logic             err_q;

  logic             any_req;
  logic             grant_dma;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_err;
  logic             burst_open;

  // Pick the winner for a grant taken this cycle.
  // On contention, DMA keeps the grant only while its locked burst still has
  // room. Otherwise the port that did not win last time gets the grant.
  always_comb begin
    any_req    = cpu_req | dma_req;
    burst_open = dma_lock && (burst_cnt < BURST_MAX);
    grant_dma  = 1'b0;
    if (cpu_req && dma_req) begin
      if (last_owner == OWNER_DMA)
        grant_dma = burst_open;
      else
        grant_dma = 1'b1;
    end else begin
      grant_dma = dma_req;
    end
  end

  // Route the winning port's request and classify it.
  // A request is rejected when it is misaligned, or when it lies outside the
  // RAM window and is not the digit register address.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
    sel_err = (sel_addr[1:0] != 2'b00) ||
              ((sel_addr >= ADDR_LIMIT) && (sel_addr != MMIO_ADDR));
  end

  // Transaction sequencer. A grant latches the request, ACCESS strobes memory
  // and captures the read data, and RESP presents the ack to the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWNER_DMA;
      burst_cnt  <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      owner      <= OWNER_CPU;
      busy       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (any_req) begin
            owner      <= grant_dma;
            last_owner <= grant_dma;
            we_q       <= sel_we;
            err_q      <= sel_err;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_wr     <= sel_we & ~sel_err;
            mem_rd     <= ~sel_we & ~sel_err;
            busy       <= 1'b1;
            if (!grant_dma) begin
              burst_cnt <= '0;
            end else if (!dma_lock) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (owner == OWNER_DMA) begin
            dma_ack   <= 1'b1;
            dma_err   <= err_q;
            dma_rdata <= (~we_q & ~err_q) ? mem_rdata : 32'h0;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_err   <= err_q;
            cpu_rdata <= (~we_q & ~err_q) ? mem_rdata : 32'h0;
          end
          state <= RESP;
        end

        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A small RAM + digit register model sits
// on the memory side. Expected acks are queued as stimulus is issued and
// checked in order by a monitor whenever either port acks.

module tb_dmem_arbiter;

  localparam logic [31:0] MMIO = 32'h4000_0010;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ack, dma_err;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          strobes = 0;
  logic [31:0] last_strobe_addr = '0;
  logic        last_strobe_wr = 1'b0;

  logic [31:0] ram [512] = '{default: 32'h0};
  logic [31:0] mmio_q = 32'h0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_lock  (dma_lock),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .dma_err   (dma_err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port of the data memory model
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr == MMIO)
      mem_rdata = mmio_q;
    else if (mem_addr < 32'h800)
      mem_rdata = ram[mem_addr[10:2]];
  end

  // Write port of the data memory model
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_addr == MMIO)
        mmio_q <= mem_wdata;
      else if (mem_addr < 32'h800)
        ram[mem_addr[10:2]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Count memory strobes and check every ack against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd || mem_wr) begin
        strobes++;
        last_strobe_addr = mem_addr;
        last_strobe_wr   = mem_wr;
      end
      if (cpu_ack || dma_ack) begin
        checkOutput("ack_overlap", 32'(cpu_ack & dma_ack), 32'h0);
        checkOutput("ack_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          checkOutput("ack_port", 32'(dma_ack), 32'(mon_e.port));
          checkOutput("ack_owner", 32'(owner), 32'(mon_e.port));
          checkOutput("ack_rdata", dma_ack ? dma_rdata : cpu_rdata, mon_e.rdata);
          checkOutput("ack_err", 32'(dma_ack ? dma_err : cpu_err), 32'(mon_e.err));
        end
      end
    end
  end

  // One access on one port, held until its ack; reports timing and strobes
  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, output int lat, output int strobe_cnt,
                               output int strobe_at);
    int   s0;
    logic got;
    pushExp(port, exp_rdata, exp_err);
    @(negedge clk);
    if (port) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    s0 = strobes;
    got = 1'b0;
    lat = 0;
    strobe_at = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && strobe_at == 0) strobe_at = i + 1;
      if (port ? dma_ack : cpu_ack) begin
        got = 1'b1;
        lat = i + 1;
      end
    end
    if (port) dma_req = 1'b0; else cpu_req = 1'b0;
    strobe_cnt = strobes - s0;
    checkOutput("ack_timeout", 32'(got), 32'h1);
  endtask

  // Both ports request together and hold until each has its quota of acks
  task automatic runContention(input logic [31:0] c_addr, input logic [31:0] d_addr,
                               input logic lock, input int n_cpu, input int n_dma);
    int c;
    int d;
    c = 0;
    d = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = c_addr; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = d_addr; dma_wdata = 32'h0;
    dma_lock = lock;
    for (int i = 0; i < 80 && (c < n_cpu || d < n_dma); i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        c++;
        if (c >= n_cpu) cpu_req = 1'b0;
      end
      if (dma_ack) begin
        d++;
        if (d >= n_dma) dma_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    dma_lock = 1'b0;
    checkOutput("cont_cpu_acks", 32'(c), 32'(n_cpu));
    checkOutput("cont_dma_acks", 32'(d), 32'(n_dma));
  endtask

  initial begin
    int lat;
    int sc;
    int sa;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    checkOutput("rst_dma_ack", 32'(dma_ack), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // CPU write then read back
    $display("[TB] cpu write/read");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, lat, sc, sa);
    checkOutput("t1_wr_latency", 32'(lat), 32'd2);
    checkOutput("t1_wr_strobes", 32'(sc), 32'd1);
    checkOutput("t1_wr_strobe_at", 32'(sa), 32'd1);
    checkOutput("t1_wr_strobe_kind", 32'(last_strobe_wr), 32'h1);
    checkOutput("t1_wr_addr", last_strobe_addr, 32'h10);
    checkOutput("t1_ram", ram[4], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, lat, sc, sa);
    checkOutput("t1_rd_latency", 32'(lat), 32'd2);
    checkOutput("t1_rd_strobes", 32'(sc), 32'd1);

    // Rejected accesses and a forwarded MMIO write
    $display("[TB] errors and mmio");
    applyStimulus(1'b0, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1, lat, sc, sa);
    checkOutput("t4_limit_strobes", 32'(sc), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h6, 32'h1111_1111, 32'h0, 1'b1, lat, sc, sa);
    checkOutput("t4_misalign_strobes", 32'(sc), 32'd0);
    applyStimulus(1'b1, 1'b1, MMIO, 32'h0000_0ABC, 32'h0, 1'b0, lat, sc, sa);
    checkOutput("t4_mmio_strobes", 32'(sc), 32'd1);
    checkOutput("t4_mmio_addr", last_strobe_addr, MMIO);
    checkOutput("t4_mmio_kind", 32'(last_strobe_wr), 32'h1);
    checkOutput("t4_mmio_reg", mmio_q, 32'h0000_0ABC);

    // Unlocked contention alternates, CPU first after a DMA grant
    $display("[TB] alternating contention");
    pushExp(1'b0, 32'hDEAD_BEEF, 1'b0);
    pushExp(1'b1, 32'h0000_0ABC, 1'b0);
    pushExp(1'b0, 32'hDEAD_BEEF, 1'b0);
    pushExp(1'b1, 32'h0000_0ABC, 1'b0);
    runContention(32'h10, MMIO, 1'b0, 2, 2);

    // Locked DMA burst is capped while the CPU waits
    $display("[TB] locked burst");
    for (int i = 0; i < 8; i++) pushExp(1'b1, 32'h0000_0ABC, 1'b0);
    pushExp(1'b0, 32'hDEAD_BEEF, 1'b0);
    pushExp(1'b1, 32'h0000_0ABC, 1'b0);
    runContention(32'h10, MMIO, 1'b1, 1, 9);

    // Reset in the middle of a write access
    $display("[TB] reset during access");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("t5_wr_in_access", 32'(mem_wr), 32'h1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t5_wr_async_drop", 32'(mem_wr), 32'h0);
    checkOutput("t5_busy_drop", 32'(busy), 32'h0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t5_no_commit", ram[12], 32'h0);
    pushExp(1'b0, 32'hDEAD_BEEF, 1'b0);
    pushExp(1'b1, 32'h0000_0ABC, 1'b0);
    runContention(32'h10, MMIO, 1'b0, 1, 1);

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM and its MMIO digit register between two requesters: the CPU MEM stage (port cpu) and a DMA/loader engine (port dma).
- Each access is latched on grant, sequenced through a fixed IDLE→ACCESS→RESP handshake, and returned with an ack pulse plus registered read data.
- Sits between the pipeline/loader and the data memory. It drives that memory's MemRd/MemWr/Addr/WrData and consumes its combinational RdData.

Parameters:
- ADDR_LIMIT, 32'h00000800, first byte address past the RAM window.
- MMIO_ADDR, 32'h40000010, the one legal address outside the RAM window (digit register).
- MAX_BURST, 8, maximum consecutive DMA grants under dma_lock while the CPU is waiting.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid with cpu_ack
cpu_err  out  1  access rejected, valid with cpu_ack
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/32/32  as cpu_*
dma_lock  in  1  request to keep the grant for the next DMA access
dma_ack, dma_rdata, dma_err  out  1/32/1  as cpu_*
mem_rd  out  1  to data memory MemRd
mem_wr  out  1  to data memory MemWr
mem_addr  out  32  to data memory Addr
mem_wdata  out  32  to data memory WrData
mem_rdata  in  32  from data memory RdData (combinational)
busy  out  1  1 in ACCESS or RESP
owner  out  1  latched owner of the current transaction (0 = CPU, 1 = DMA)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE. All outputs go to 0.
  - last_owner=DMA, burst_cnt=0.
  - Any in-flight transaction is dropped: no ack is issued and no memory strobe follows.
- FSM IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise pick a winner. Latch owner, we, addr, wdata and err_q, then go to ACCESS.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: DMA wins iff last_owner=DMA, dma_lock=1 and burst_cnt<MAX_BURST. Otherwise the winner is the port that is not last_owner.
  - On a grant, last_owner takes the winner.
- burst_cnt (width clog2(MAX_BURST+1)):
  - On a DMA grant with dma_lock=1: increment, saturating at MAX_BURST.
  - On a DMA grant with dma_lock=0: set to 0.
  - On a CPU grant: set to 0.
  - Without contention, DMA may exceed MAX_BURST consecutive grants; the counter saturates.
- err_q = 1 when:
  - addr[1:0]≠0, or
  - addr≥ADDR_LIMIT and addr≠MMIO_ADDR.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched values.
  - mem_wr = we_q & ~err_q. mem_rd = ~we_q & ~err_q.
  - All memory outputs decode from registers only, with no combinational path from req inputs.
  - On a read, mem_rdata is captured at the end of the cycle. The write commits at the same edge.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - The owner's ack=1 and err=err_q.
  - rdata = captured data for a valid read, else 0.
  - The non-owner's ack stays 0.
  - Go to IDLE.
  - rdata/err hold their values until the next ack on that port.
- Outside ACCESS, mem_rd=mem_wr=0 and mem_addr/mem_wdata hold their last values.
- Latency and throughput:
  - A req first seen high in IDLE at cycle N gives the memory strobe in N+1 and the ack in N+2.
  - Peak rate is one access per 3 cycles.
- Handshake rules:
  - The requester holds req/we/addr/wdata stable until it sees ack.
  - Changes after the grant are ignored, since the access uses the latched values.
  - A req still high in the cycle after ack (IDLE) is a new request.
  - Dropping req before ack is illegal; the transaction still completes and acks.
- An erroneous access produces no memory strobe and is acked normally with err=1.
- MMIO: an access to MMIO_ADDR is forwarded normally; the memory handles the digit register.

Test Plan:
1. Reset, then CPU write 0x00000010←0xDEADBEEF, then CPU read 0x10 → mem_wr=1 in cycle N+1 only; cpu_ack at N+2; read returns cpu_rdata=0xDEADBEEF, cpu_err=0.
2. cpu_req and dma_req rise together, both held through two rounds, dma_lock=0 → grants CPU, DMA, CPU, DMA; acks never overlap; owner toggles.
3. DMA streams with dma_lock=1 and CPU requesting throughout → exactly 8 DMA acks, then a CPU ack, then burst_cnt=0 and DMA is granted again.
4. CPU read 0x00000800, CPU write 0x00000006, DMA write 0x40000010←0x00000ABC → the first two are acked with err=1 and no strobe; the third gives mem_wr=1 with mem_addr=0x40000010, err=0.
5. Assert rst=0 during ACCESS of a write → mem_wr drops to 0 immediately, no ack after release, state returns to IDLE, next contention grants CPU first.
